// File: rtl/cmd_slot_sched_pkg.sv
// Shared SATA host definitions: scheduler FSM encoding and command-type codes.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cmd_slot_sched_pkg;

    // Scheduler FSM encoding, kept as plain constants for legacy tools.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    // 3-bit command-type codes carried in each slot.
    typedef enum logic [2:0] {
        CMD_NOP       = 3'h0,
        CMD_READ_DMA  = 3'h1,
        CMD_WRITE_DMA = 3'h2,
        CMD_FLUSH     = 3'h3,
        CMD_IDENTIFY  = 3'h4,
        CMD_READ_FPDMA  = 3'h5,
        CMD_WRITE_FPDMA = 3'h6,
        CMD_VENDOR    = 3'h7
    } cmd_type_e;

endpackage

// File: rtl/cmd_slot_sched_rr_pick.sv
// Round-robin first-set finder: lowest set request bit at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld is low when no request bit is set.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Scan from ptr upward; the index sum wraps naturally because N is a power of 2.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!vld && req[ptr + IW'(i)]) begin
                vld = 1'b1;
                idx = ptr + IW'(i);
            end
        end
    end

endmodule

// File: rtl/cmd_slot_sched.sv
// Command slot scheduler: round-robin issue of loaded slots to the transport layer.
// Latency: slot_wr -> ISSUE in 1 cycle, cmd_val the cycle after; one IDLE cycle between commands.
// Backpressure: cmd_busy holds the command in ISSUE with cmd_val low until the transport frees up.
module cmd_slot_sched
    import cmd_slot_sched_pkg::*;
#(
    parameter int NSLOTS = 4,
    parameter int TMO_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      slot_wr,
    input  logic [$clog2(NSLOTS)-1:0] slot_wr_idx,
    input  logic [2:0]                slot_wr_type,
    input  logic [3:0]                slot_wr_port,
    input  logic [NSLOTS-1:0]         slot_clr,
    input  logic                      abort,
    input  logic [TMO_W-1:0]          tmo_limit,
    output logic [NSLOTS-1:0]         slot_pend,
    output logic [NSLOTS-1:0]         slot_act,
    output logic [NSLOTS-1:0]         slot_done,
    output logic [NSLOTS-1:0]         slot_err,
    output logic                      tmo_flag,
    output logic [2:0]                cmd_type,
    output logic [3:0]                cmd_port,
    output logic                      cmd_val,
    input  logic                      cmd_busy,
    input  logic                      cmd_done_good,
    input  logic                      cmd_done_bad
);

    localparam int IW = $clog2(NSLOTS);

    logic [1:0]       state;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    act_idx;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       act_type;
    logic [3:0]       act_port;
    logic [2:0]       type_mem [NSLOTS];
    logic [3:0]       port_mem [NSLOTS];

    logic              pick_vld;
    logic [IW-1:0]     pick_idx;
    logic              in_idle, in_issue, in_wait;
    logic              pick, wr_ok, issue_abort, tmo_hit;
    logic              fin_good, fin_err, complete;
    logic [NSLOTS-1:0] act_mask, wr_mask, pick_mask;

    rr_pick #(.N(NSLOTS), .IW(IW)) u_rr_pick (
        .req (slot_pend),
        .ptr (rr_ptr),
        .vld (pick_vld),
        .idx (pick_idx)
    );

    assign in_idle  = (state == ST_IDLE);
    assign in_issue = (state == ST_ISSUE);
    assign in_wait  = (state == ST_WAIT_DONE);
    assign pick     = in_idle & pick_vld;

    // Writes into a slot that is still queued or running are dropped.
    assign wr_ok = slot_wr & ~slot_pend[slot_wr_idx] & ~slot_act[slot_wr_idx];

    // Abort during ISSUE suppresses the strobe so the transport never sees the command.
    assign cmd_val     = in_issue & ~cmd_busy & ~abort;
    assign issue_abort = in_issue & abort;

    assign tmo_hit  = (tmo_limit != '0) && ((tmo_cnt + TMO_W'(1)) == tmo_limit);

    // Completion priority: bad > good > abort > timeout.
    assign fin_good = in_wait & ~cmd_done_bad & cmd_done_good;
    assign fin_err  = (in_wait & (cmd_done_bad | (~cmd_done_good & (abort | tmo_hit)))) | issue_abort;
    assign complete = fin_good | fin_err;

    assign act_mask  = NSLOTS'(1) << act_idx;
    assign wr_mask   = wr_ok ? (NSLOTS'(1) << slot_wr_idx) : '0;
    assign pick_mask = pick  ? (NSLOTS'(1) << pick_idx)    : '0;

    assign cmd_type = in_idle ? 3'h0 : act_type;
    assign cmd_port = in_idle ? 4'h0 : act_port;

    // Scheduler FSM: pick, issue with backpressure, then wait for completion or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            act_idx  <= '0;
            act_type <= CMD_NOP;
            act_port <= '0;
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state    <= ST_ISSUE;
                        act_idx  <= pick_idx;
                        act_type <= type_mem[pick_idx];
                        act_port <= port_mem[pick_idx];
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state  <= ST_IDLE;
                        rr_ptr <= act_idx + IW'(1);
                    end else if (!cmd_busy) begin
                        state   <= ST_WAIT_DONE;
                        tmo_cnt <= '0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (complete) begin
                        state  <= ST_IDLE;
                        rr_ptr <= act_idx + IW'(1);
                        if (!cmd_done_bad && !cmd_done_good && !abort)
                            tmo_flag <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Per-slot flags and stored command fields; a load overrides a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_pend <= '0;
            slot_act  <= '0;
            slot_done <= '0;
            slot_err  <= '0;
            for (int i = 0; i < NSLOTS; i++) begin
                type_mem[i] <= CMD_NOP;
                port_mem[i] <= '0;
            end
        end else begin
            slot_pend <= (slot_pend & ~pick_mask) | wr_mask;
            slot_act  <= pick ? pick_mask : (complete ? '0 : slot_act);
            slot_done <= ((slot_done & ~slot_clr) | (fin_good ? act_mask : '0)) & ~wr_mask;
            slot_err  <= ((slot_err  & ~slot_clr) | (fin_err  ? act_mask : '0)) & ~wr_mask;
            if (wr_ok) begin
                type_mem[slot_wr_idx] <= slot_wr_type;
                port_mem[slot_wr_idx] <= slot_wr_port;
            end
        end
    end

endmodule

// File: tb/tb_cmd_slot_sched.sv
// Bench for cmd_slot_sched: directed scenarios plus a randomized run against a slot-set model.
// Latency: checks issue latency, timeout timing and back-to-back round-robin ordering.
// Backpressure: drives cmd_busy both directed and randomly while commands wait in ISSUE.
module tb_cmd_slot_sched;

    localparam int NS = 4;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          slot_wr;
    logic [1:0]    slot_wr_idx;
    logic [2:0]    slot_wr_type;
    logic [3:0]    slot_wr_port;
    logic [NS-1:0] slot_clr;
    logic          abort;
    logic [TW-1:0] tmo_limit;
    logic [NS-1:0] slot_pend, slot_act, slot_done, slot_err;
    logic          tmo_flag;
    logic [2:0]    cmd_type;
    logic [3:0]    cmd_port;
    logic          cmd_val;
    logic          cmd_busy, cmd_done_good, cmd_done_bad;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    cmd_slot_sched #(.NSLOTS(NS), .TMO_W(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .slot_wr       (slot_wr),
        .slot_wr_idx   (slot_wr_idx),
        .slot_wr_type  (slot_wr_type),
        .slot_wr_port  (slot_wr_port),
        .slot_clr      (slot_clr),
        .abort         (abort),
        .tmo_limit     (tmo_limit),
        .slot_pend     (slot_pend),
        .slot_act      (slot_act),
        .slot_done     (slot_done),
        .slot_err      (slot_err),
        .tmo_flag      (tmo_flag),
        .cmd_type      (cmd_type),
        .cmd_port      (cmd_port),
        .cmd_val       (cmd_val),
        .cmd_busy      (cmd_busy),
        .cmd_done_good (cmd_done_good),
        .cmd_done_bad  (cmd_done_bad)
    );

    function automatic int ty(input int s);
        return (s * 3 + 2) % 8;
    endfunction

    function automatic int pt(input int s);
        return (s * 5 + 1) % 16;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        slot_wr = 1'b0; slot_wr_idx = '0; slot_wr_type = '0; slot_wr_port = '0;
        slot_clr = '0; abort = 1'b0; cmd_busy = 1'b0;
        cmd_done_good = 1'b0; cmd_done_bad = 1'b0; tmo_limit = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle_cyc();
        @(negedge clk);
        slot_wr = 1'b0; slot_clr = '0; abort = 1'b0;
        cmd_done_good = 1'b0; cmd_done_bad = 1'b0;
    endtask

    task automatic wr(input int idx, input int t, input int p);
        @(negedge clk);
        slot_clr = '0; abort = 1'b0; cmd_done_good = 1'b0; cmd_done_bad = 1'b0;
        slot_wr = 1'b1;
        slot_wr_idx  = 2'(idx);
        slot_wr_type = 3'(t);
        slot_wr_port = 4'(p);
    endtask

    // Advance until cmd_val is seen (bounded); returns in the accept cycle.
    task automatic wait_accept(input bit rnd_busy, output int idx, output bit ok);
        ok = 1'b0;
        idx = -1;
        for (int c = 0; c < 64 && !ok; c++) begin
            idle_cyc();
            cmd_busy = rnd_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            if (cmd_val) begin
                ok = 1'b1;
                for (int i = 0; i < NS; i++) if (slot_act[i]) idx = i;
            end
        end
    endtask

    task automatic pulse(input bit g, input bit b, input bit a);
        @(negedge clk);
        slot_wr = 1'b0; slot_clr = '0; cmd_busy = 1'b0;
        cmd_done_good = g; cmd_done_bad = b; abort = a;
        @(negedge clk);
        cmd_done_good = 1'b0; cmd_done_bad = 1'b0; abort = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (slot_pend !== 4'b0) begin n_fail++; $display("FAIL reset_pend got %b exp 0000", slot_pend); end
        n_tests++; if (slot_act !== 4'b0) begin n_fail++; $display("FAIL reset_act got %b exp 0000", slot_act); end
        n_tests++; if ({slot_done, slot_err} !== 8'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0", {slot_done, slot_err}); end
        n_tests++; if ({tmo_flag, cmd_val, cmd_type, cmd_port} !== 9'b0) begin n_fail++; $display("FAIL reset_cmd got %b exp 0", {tmo_flag, cmd_val, cmd_type, cmd_port}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int idx, t0;
        bit ok;
        do_reset();
        wr(0, 2, 1);
        t0 = cyc_cnt;
        wait_accept(1'b0, idx, ok);
        n_tests++; if (!ok || (cyc_cnt - t0) != 2) begin n_fail++; $display("FAIL single_latency got %0d exp 2 (seen=%0d)", cyc_cnt - t0, ok); end
        n_tests++; if (cmd_type !== 3'h2 || cmd_port !== 4'h1) begin n_fail++; $display("FAIL single_cmd got %h/%h exp 2/1", cmd_type, cmd_port); end
        n_tests++; if (slot_act !== 4'b0001) begin n_fail++; $display("FAIL single_act got %b exp 0001", slot_act); end
        idle_cyc(); #1;
        n_tests++; if (cmd_val !== 1'b0) begin n_fail++; $display("FAIL single_val_width got %b exp 0", cmd_val); end
        repeat (3) idle_cyc();
        pulse(1'b1, 1'b0, 1'b0);
        n_tests++; if (slot_done !== 4'b0001 || slot_err !== 4'b0) begin n_fail++; $display("FAIL single_done got done=%b err=%b exp 0001/0000", slot_done, slot_err); end
        n_tests++; if (slot_act !== 4'b0 || cmd_type !== 3'h0 || cmd_port !== 4'h0) begin n_fail++; $display("FAIL single_idle got act=%b type=%h port=%h exp 0", slot_act, cmd_type, cmd_port); end
    endtask

    task automatic test_rr_wrap();
        int exp_ord[5] = '{1, 2, 3, 0, 1};
        int idx;
        bit ok;
        do_reset();
        wr(0, ty(0), pt(0));
        wait_accept(1'b0, idx, ok);
        n_tests++; if (!ok || idx != 0) begin n_fail++; $display("FAIL rr_first got %0d exp 0", idx); end
        wr(3, ty(3), pt(3));
        wr(1, ty(1), pt(1));
        wr(2, ty(2), pt(2));
        pulse(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            wait_accept(1'b0, idx, ok);
            n_tests++; if (!ok || idx != exp_ord[k]) begin n_fail++; $display("FAIL rr_order step %0d got %0d exp %0d", k, idx, exp_ord[k]); end
            n_tests++; if (ok && (cmd_type !== 3'(ty(idx)) || cmd_port !== 4'(pt(idx)))) begin n_fail++; $display("FAIL rr_fields step %0d got %h/%h exp %h/%h", k, cmd_type, cmd_port, 3'(ty(idx)), 4'(pt(idx))); end
            if (k == 2) begin
                wr(0, ty(0), pt(0));
                wr(1, ty(1), pt(1));
            end
            pulse(1'b1, 1'b0, 1'b0);
        end
        n_tests++; if (slot_done !== 4'b1111 || slot_pend !== 4'b0) begin n_fail++; $display("FAIL rr_final got done=%b pend=%b exp 1111/0000", slot_done, slot_pend); end
    endtask

    task automatic test_timeout();
        int idx;
        bit ok;
        do_reset();
        tmo_limit = 16'd10;
        wr(2, 1, 1);
        wait_accept(1'b0, idx, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_accept got none exp cmd_val"); end
        for (int c = 1; c <= 11; c++) begin
            idle_cyc(); #1;
            if (c == 10) begin
                n_tests++; if (slot_err !== 4'b0 || tmo_flag !== 1'b0 || slot_act !== 4'b0100) begin n_fail++; $display("FAIL tmo_early got err=%b tmo=%b act=%b exp 0000/0/0100", slot_err, tmo_flag, slot_act); end
            end
            if (c == 11) begin
                n_tests++; if (slot_err !== 4'b0100 || tmo_flag !== 1'b1 || slot_act !== 4'b0) begin n_fail++; $display("FAIL tmo_fire got err=%b tmo=%b act=%b exp 0100/1/0000", slot_err, tmo_flag, slot_act); end
            end
        end
        repeat (5) idle_cyc();
        #1;
        n_tests++; if (tmo_flag !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got %b exp 1", tmo_flag); end
    endtask

    task automatic test_no_timeout();
        int idx;
        bit ok;
        do_reset();
        tmo_limit = '0;
        wr(1, 4, 2);
        wait_accept(1'b0, idx, ok);
        repeat (70000) idle_cyc();
        #1;
        n_tests++; if (!ok || slot_act !== 4'b0010 || slot_err !== 4'b0 || tmo_flag !== 1'b0) begin n_fail++; $display("FAIL notmo got act=%b err=%b tmo=%b exp 0010/0000/0", slot_act, slot_err, tmo_flag); end
        pulse(1'b1, 1'b0, 1'b0);
        n_tests++; if (slot_done !== 4'b0010) begin n_fail++; $display("FAIL notmo_done got %b exp 0010", slot_done); end
    endtask

    task automatic test_busy();
        do_reset();
        cmd_busy = 1'b1;
        wr(2, 3, 5);
        idle_cyc();
        for (int c = 0; c < 7; c++) begin
            idle_cyc();
            if (c == 3) cmd_done_good = 1'b1;
            #1;
            n_tests++; if (cmd_val !== 1'b0) begin n_fail++; $display("FAIL busy_hold cycle %0d got %b exp 0", c, cmd_val); end
        end
        n_tests++; if (slot_act !== 4'b0100 || slot_done !== 4'b0) begin n_fail++; $display("FAIL busy_issue got act=%b done=%b exp 0100/0000", slot_act, slot_done); end
        idle_cyc();
        cmd_busy = 1'b0;
        #1;
        n_tests++; if (cmd_val !== 1'b1 || cmd_type !== 3'h3 || cmd_port !== 4'h5) begin n_fail++; $display("FAIL busy_release got val=%b %h/%h exp 1 3/5", cmd_val, cmd_type, cmd_port); end
        pulse(1'b1, 1'b1, 1'b0);
        n_tests++; if (slot_err !== 4'b0100 || slot_done !== 4'b0) begin n_fail++; $display("FAIL both_done got err=%b done=%b exp 0100/0000", slot_err, slot_done); end
    endtask

    task automatic test_abort_issue();
        bit seen;
        do_reset();
        cmd_busy = 1'b1;
        wr(1, 3, 3);
        idle_cyc();
        idle_cyc(); #1;
        n_tests++; if (slot_act !== 4'b0010) begin n_fail++; $display("FAIL abort_pre got act=%b exp 0010", slot_act); end
        idle_cyc();
        abort = 1'b1; cmd_busy = 1'b0;
        #1;
        n_tests++; if (cmd_val !== 1'b0) begin n_fail++; $display("FAIL abort_val got %b exp 0", cmd_val); end
        idle_cyc(); #1;
        n_tests++; if (slot_err !== 4'b0010 || slot_act !== 4'b0 || slot_done !== 4'b0) begin n_fail++; $display("FAIL abort_flags got err=%b act=%b done=%b exp 0010/0000/0000", slot_err, slot_act, slot_done); end
        seen = 1'b0;
        repeat (5) begin idle_cyc(); #1; if (cmd_val) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_quiet got cmd_val=1 exp 0"); end
    endtask

    task automatic test_reset_mid();
        int idx;
        bit ok, seen;
        do_reset();
        tmo_limit = 16'd3;
        wr(3, 1, 1);
        wait_accept(1'b0, idx, ok);
        repeat (4) idle_cyc();
        tmo_limit = '0;
        wr(0, 5, 9);
        wait_accept(1'b0, idx, ok);
        wr(1, 2, 2);
        wr(0, 6, 6);
        idle_cyc(); #1;
        n_tests++; if (slot_pend !== 4'b0010 || cmd_type !== 3'h5 || slot_act !== 4'b0001 || tmo_flag !== 1'b1) begin n_fail++; $display("FAIL wr_active got pend=%b type=%h act=%b tmo=%b exp 0010/5/0001/1", slot_pend, cmd_type, slot_act, tmo_flag); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if ({slot_pend, slot_act, slot_done, slot_err} !== 16'b0) begin n_fail++; $display("FAIL async_rst_slots got %b exp 0", {slot_pend, slot_act, slot_done, slot_err}); end
        n_tests++; if ({tmo_flag, cmd_val, cmd_type, cmd_port} !== 9'b0) begin n_fail++; $display("FAIL async_rst_cmd got %b exp 0", {tmo_flag, cmd_val, cmd_type, cmd_port}); end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin idle_cyc(); #1; if (cmd_val || slot_act != 4'b0 || slot_pend != 4'b0) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL post_rst_quiet got activity exp none"); end
    endtask

    task automatic test_wr_clr();
        int idx;
        bit ok;
        do_reset();
        wr(2, 4, 4);
        wait_accept(1'b0, idx, ok);
        pulse(1'b1, 1'b0, 1'b0);
        n_tests++; if (slot_done !== 4'b0100) begin n_fail++; $display("FAIL wrclr_pre got %b exp 0100", slot_done); end
        wr(2, 7, 7);
        slot_clr = 4'b0100;
        idle_cyc(); #1;
        n_tests++; if (slot_pend !== 4'b0100 || slot_done !== 4'b0) begin n_fail++; $display("FAIL wrclr got pend=%b done=%b exp 0100/0000", slot_pend, slot_done); end
        wait_accept(1'b0, idx, ok);
        n_tests++; if (!ok || cmd_type !== 3'h7) begin n_fail++; $display("FAIL wrclr_type got %h exp 7", cmd_type); end
        pulse(1'b0, 1'b1, 1'b0);
        idle_cyc();
        slot_clr = 4'b0100;
        idle_cyc(); #1;
        n_tests++; if (slot_err !== 4'b0) begin n_fail++; $display("FAIL clr_only got %b exp 0000", slot_err); end
    endtask

    task automatic test_random();
        bit         m_pend[4], m_done[4], m_err[4];
        int         m_type[4], m_port[4];
        int         m_rr, exp_i, idx, i, t, p, nw, d, r;
        bit         ok, g, b, a;
        logic [3:0] vp, vd, ve, msk;
        do_reset();
        m_rr = 0;
        for (int k = 0; k < 4; k++) begin
            m_pend[k] = 0; m_done[k] = 0; m_err[k] = 0; m_type[k] = 0; m_port[k] = 0;
        end
        for (int it = 0; it < 40; it++) begin
            if (!(m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3])) begin
                i = $urandom_range(0, 3); t = $urandom_range(0, 7); p = $urandom_range(0, 15);
                wr(i, t, p);
                m_pend[i] = 1; m_type[i] = t; m_port[i] = p; m_done[i] = 0; m_err[i] = 0;
            end
            exp_i = -1;
            for (int k = 0; k < 4; k++)
                if (exp_i < 0 && m_pend[(m_rr + k) % 4]) exp_i = (m_rr + k) % 4;
            wait_accept(1'b1, idx, ok);
            n_tests++;
            if (!ok || idx != exp_i) begin
                n_fail++;
                $display("FAIL rand_issue it=%0d got slot %0d exp %0d", it, idx, exp_i);
                return;
            end
            n_tests++;
            if (cmd_type !== 3'(m_type[exp_i]) || cmd_port !== 4'(m_port[exp_i])) begin
                n_fail++;
                $display("FAIL rand_fields it=%0d got %h/%h exp %h/%h", it, cmd_type, cmd_port, 3'(m_type[exp_i]), 4'(m_port[exp_i]));
            end
            m_pend[exp_i] = 0;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                i = $urandom_range(0, 3); t = $urandom_range(0, 7); p = $urandom_range(0, 15);
                wr(i, t, p);
                if (!m_pend[i] && i != exp_i) begin
                    m_pend[i] = 1; m_type[i] = t; m_port[i] = p; m_done[i] = 0; m_err[i] = 0;
                end
            end
            d = $urandom_range(0, 3);
            for (int j = 0; j < d; j++) begin
                idle_cyc();
                if (j == 0) begin
                    msk = 4'($urandom);
                    slot_clr = msk;
                    for (int k = 0; k < 4; k++) if (msk[k]) begin m_done[k] = 0; m_err[k] = 0; end
                end
            end
            r = $urandom_range(0, 3);
            g = (r == 0 || r == 2);
            b = (r == 1 || r == 2);
            a = (r == 3) || ($urandom_range(0, 3) == 0);
            pulse(g, b, a);
            if (b || (!g && a)) m_err[exp_i] = 1; else m_done[exp_i] = 1;
            m_rr = (exp_i + 1) % 4;
            for (int k = 0; k < 4; k++) begin
                vp[k] = m_pend[k]; vd[k] = m_done[k]; ve[k] = m_err[k];
            end
            n_tests++;
            if (slot_done !== vd || slot_err !== ve || slot_pend !== vp || slot_act !== 4'b0) begin
                n_fail++;
                $display("FAIL rand_flags it=%0d got done=%b err=%b pend=%b act=%b exp %b/%b/%b/0000",
                         it, slot_done, slot_err, slot_pend, slot_act, vd, ve, vp);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got no finish exp finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_rr_wrap();
        test_timeout();
        test_no_timeout();
        test_busy();
        test_abort_issue();
        test_reset_mid();
        test_wr_clr();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
